reg_file_sb: RTL and testbench

Parametrised successor to the 8x16 CPU register file. Generalised width and depth, two write ports (ALU writeback and load writeback), optional hardwired-zero R0, optional write-to-read bypass, and a per-register pending-write scoreboard. The decode stage uses the scoreboard to detect RAW hazards. Sits between decode (read/mark) and the writeback stages (write/clear).

---
 rtl/reg_file_sb.sv | 134 +++++++++++++
 tb/tb_reg_file_sb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two read ports, two write ports
// (ALU and load writeback), optional hardwired-zero R0, optional write-to-read
// bypass and a per-register pending-write scoreboard for RAW hazard detection.
module reg_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] bus_A,
  output logic [DATA_W-1:0] bus_B,
  output logic              busy_A,
  output logic              busy_B,
  input  logic              we0,
  input  logic [ADDR_W-1:0] RW0,
  input  logic [DATA_W-1:0] bus_w0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] RW1,
  input  logic [DATA_W-1:0] bus_w1,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic              any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pending_next;
  logic [ADDR_W-1:0] rd_addr [2];

  // A write or mark aimed at a hardwired-zero R0 is treated as if it never happened.
  logic wr0_ok;
  logic wr1_ok;
  logic mark_ok;

  // Qualify write and mark requests against the hardwired-zero register.
  always_comb begin
    wr0_ok  = we0;
    wr1_ok  = we1;
    mark_ok = mark_en;
    if (R0_ZERO != 0) begin
      if (RW0 == '0)       wr0_ok  = 1'b0;
      if (RW1 == '0)       wr1_ok  = 1'b0;
      if (mark_addr == '0) mark_ok = 1'b0;
    end
  end

  // Register array update; the load port wins an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr1_ok && (RW1 == ADDR_W'(i))) begin
          regs_reg[i] <= bus_w1;
        end else if (wr0_ok && (RW0 == ADDR_W'(i))) begin
          regs_reg[i] <= bus_w0;
        end
      end
    end
  end

  // Scoreboard next state: writes retire a producer, a mark issues a new one and
  // takes precedence so a same-cycle mark and write leaves the register pending.
  always_comb begin
    pending_next = pending_reg;
    for (int i = 0; i < DEPTH; i++) begin
      if ((wr0_ok && (RW0 == ADDR_W'(i))) || (wr1_ok && (RW1 == ADDR_W'(i)))) begin
        pending_next[i] = 1'b0;
      end
      if (mark_ok && (mark_addr == ADDR_W'(i))) begin
        pending_next[i] = 1'b1;
      end
    end
    if (R0_ZERO != 0) begin
      pending_next[0] = 1'b0;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign rd_addr[0] = RA;
  assign rd_addr[1] = RB;

  // One identical read path per port: array, then bypass, then R0 and reset overrides.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] data;
    logic              busy;

    // Resolve read data and busy flag for this port.
    always_comb begin
      data = regs_reg[rd_addr[gi]];
      busy = pending_reg[rd_addr[gi]];
      if ((BYPASS != 0) && !rst) begin
        if (wr1_ok && (RW1 == rd_addr[gi])) begin
          data = bus_w1;
          busy = 1'b0;
        end else if (wr0_ok && (RW0 == rd_addr[gi])) begin
          data = bus_w0;
          busy = 1'b0;
        end
      end
      if ((R0_ZERO != 0) && (rd_addr[gi] == '0)) begin
        data = '0;
        busy = 1'b0;
      end
      if (rst) begin
        data = '0;
        busy = 1'b0;
      end
    end
  end

  assign bus_A    = g_rd[0].data;
  assign bus_B    = g_rd[1].data;
  assign busy_A   = g_rd[0].busy;
  assign busy_B   = g_rd[1].busy;
  assign any_busy = |pending_reg;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vectors for reg_file_sb in its default configuration,
// with bypass disabled, and in a 32x32 configuration.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;

  // Shared stimulus for the 16-bit default and no-bypass instances.
  logic [2:0]  ra, rb, rw0, rw1, mark_addr;
  logic [15:0] bus_w0, bus_w1;
  logic        we0, we1, mark_en;
  logic [15:0] d_bus_a, d_bus_b, n_bus_a, n_bus_b;
  logic        d_busy_a, d_busy_b, d_any, n_busy_a, n_busy_b, n_any;

  // Stimulus for the wide instance.
  logic [4:0]  w_ra, w_rb, w_rw0, w_rw1, w_mark_addr;
  logic [31:0] w_bus_w0, w_bus_w1, w_bus_a, w_bus_b;
  logic        w_we0, w_we1, w_mark_en, w_busy_a, w_busy_b, w_any;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .RA(ra), .RB(rb), .bus_A(d_bus_a), .bus_B(d_bus_b),
    .busy_A(d_busy_a), .busy_B(d_busy_b), .we0(we0), .RW0(rw0), .bus_w0(bus_w0),
    .we1(we1), .RW1(rw1), .bus_w1(bus_w1), .mark_en(mark_en), .mark_addr(mark_addr),
    .any_busy(d_any)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .RA(ra), .RB(rb), .bus_A(n_bus_a), .bus_B(n_bus_b),
    .busy_A(n_busy_a), .busy_B(n_busy_b), .we0(we0), .RW0(rw0), .bus_w0(bus_w0),
    .we1(we1), .RW1(rw1), .bus_w1(bus_w1), .mark_en(mark_en), .mark_addr(mark_addr),
    .any_busy(n_any)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1), .BYPASS(1)) u_dut_w (
    .clk(clk), .rst(rst), .RA(w_ra), .RB(w_rb), .bus_A(w_bus_a), .bus_B(w_bus_b),
    .busy_A(w_busy_a), .busy_B(w_busy_b), .we0(w_we0), .RW0(w_rw0), .bus_w0(w_bus_w0),
    .we1(w_we1), .RW1(w_rw1), .bus_w1(w_bus_w1), .mark_en(w_mark_en),
    .mark_addr(w_mark_addr), .any_busy(w_any)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ra = '0; rb = '0; rw0 = '0; rw1 = '0; mark_addr = '0;
    bus_w0 = '0; bus_w1 = '0; we0 = 1'b0; we1 = 1'b0; mark_en = 1'b0;
    w_ra = '0; w_rb = '0; w_rw0 = '0; w_rw1 = '0; w_mark_addr = '0;
    w_bus_w0 = '0; w_bus_w1 = '0; w_we0 = 1'b0; w_we1 = 1'b0; w_mark_en = 1'b0;

    // Reset state
    ra = 3'd3;
    #1;
    chk("rst_bus_A", 32'(d_bus_a), 32'h0);
    chk("rst_busy_A", 32'(d_busy_a), 32'h0);
    chk("rst_any_busy", 32'(d_any), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Write R3, mark R3, then asynchronous reset between edges
    we0 = 1'b1; rw0 = 3'd3; bus_w0 = 16'h1234;
    tick();
    we0 = 1'b0; mark_en = 1'b1; mark_addr = 3'd3;
    tick();
    mark_en = 1'b0;
    #1;
    chk("r3_written", 32'(d_bus_a), 32'h1234);
    chk("r3_busy", 32'(d_busy_a), 32'h1);
    chk("r3_any_busy", 32'(d_any), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_bus_A", 32'(d_bus_a), 32'h0);
    chk("async_rst_busy_A", 32'(d_busy_a), 32'h0);
    chk("async_rst_any_busy", 32'(d_any), 32'h0);
    we0 = 1'b1; rw0 = 3'd3; bus_w0 = 16'h5555;
    #1;
    chk("rst_no_bypass", 32'(d_bus_a), 32'h0);
    tick();
    we0 = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_write_dropped", 32'(d_bus_a), 32'h0);

    // Dual-write collision: load port wins, also under bypass
    we0 = 1'b1; we1 = 1'b1; rw0 = 3'd5; rw1 = 3'd5;
    bus_w0 = 16'h00AA; bus_w1 = 16'h00BB; ra = 3'd5;
    #1;
    chk("collide_bypass", 32'(d_bus_a), 32'h00BB);
    chk("collide_nb_old", 32'(n_bus_a), 32'h0);
    tick();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    chk("collide_stored", 32'(d_bus_a), 32'h00BB);
    chk("collide_nb_stored", 32'(n_bus_a), 32'h00BB);

    // Independent writes on both ports
    we0 = 1'b1; rw0 = 3'd1; bus_w0 = 16'h1111;
    we1 = 1'b1; rw1 = 3'd6; bus_w1 = 16'h6666;
    tick();
    we0 = 1'b0; we1 = 1'b0; ra = 3'd1; rb = 3'd6;
    #1;
    chk("dual_r1", 32'(d_bus_a), 32'h1111);
    chk("dual_r6", 32'(d_bus_b), 32'h6666);

    // Bypass vs no bypass
    we0 = 1'b1; rw0 = 3'd2; bus_w0 = 16'h0F0F; ra = 3'd2;
    #1;
    chk("bypass_same_cycle", 32'(d_bus_a), 32'h0F0F);
    chk("nb_same_cycle_old", 32'(n_bus_a), 32'h0);
    tick();
    we0 = 1'b0;
    #1;
    chk("nb_next_cycle", 32'(n_bus_a), 32'h0F0F);

    // Scoreboard: mark R4, then retire it from the load port
    mark_en = 1'b1; mark_addr = 3'd4; ra = 3'd4;
    tick();
    mark_en = 1'b0;
    #1;
    chk("sb_mark_busy", 32'(d_busy_a), 32'h1);
    chk("sb_mark_any", 32'(d_any), 32'h1);
    we1 = 1'b1; rw1 = 3'd4; bus_w1 = 16'h4444;
    #1;
    chk("sb_wr_busy_bypass", 32'(d_busy_a), 32'h0);
    chk("sb_wr_busy_nb", 32'(n_busy_a), 32'h1);
    chk("sb_wr_data_bypass", 32'(d_bus_a), 32'h4444);
    tick();
    we1 = 1'b0;
    #1;
    chk("sb_cleared_busy", 32'(d_busy_a), 32'h0);
    chk("sb_cleared_nb", 32'(n_busy_a), 32'h0);
    chk("sb_cleared_any", 32'(d_any), 32'h0);

    // Mark and write same register in one cycle: mark wins
    mark_en = 1'b1; mark_addr = 3'd4; we0 = 1'b1; rw0 = 3'd4; bus_w0 = 16'h5678;
    tick();
    mark_en = 1'b0; we0 = 1'b0;
    #1;
    chk("sb_mark_wins_busy", 32'(d_busy_a), 32'h1);
    chk("sb_mark_wins_data", 32'(d_bus_a), 32'h5678);
    chk("sb_mark_wins_any", 32'(d_any), 32'h1);

    // R0 hardwired zero: write and mark ignored, R4 still pending
    we0 = 1'b1; rw0 = 3'd0; bus_w0 = 16'hFFFF; mark_en = 1'b1; mark_addr = 3'd0; ra = 3'd0;
    #1;
    chk("r0_bypass_zero", 32'(d_bus_a), 32'h0);
    tick();
    we0 = 1'b0; mark_en = 1'b0;
    #1;
    chk("r0_read_zero", 32'(d_bus_a), 32'h0);
    chk("r0_busy_zero", 32'(d_busy_a), 32'h0);
    chk("r0_any_unaffected", 32'(d_any), 32'h1);

    // Retire R4 so nothing is pending
    we0 = 1'b1; rw0 = 3'd4; bus_w0 = 16'h0004;
    tick();
    we0 = 1'b0;
    #1;
    chk("all_retired_any", 32'(d_any), 32'h0);

    // Wide configuration: 32-bit data, 32 registers
    w_we0 = 1'b1; w_rw0 = 5'd31; w_bus_w0 = 32'hDEADBEEF;
    tick();
    w_we0 = 1'b0; w_rb = 5'd31;
    #1;
    chk("wide_r31_port_b", 32'(w_bus_b), 32'hDEADBEEF);
    chk("wide_r31_idle", 32'(w_busy_b), 32'h0);
    w_mark_en = 1'b1; w_mark_addr = 5'd31;
    tick();
    w_mark_en = 1'b0;
    #1;
    chk("wide_r31_busy_b", 32'(w_busy_b), 32'h1);
    chk("wide_any_busy", 32'(w_any), 32'h1);
    chk("wide_r0_zero", 32'(w_bus_a), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
